ltc2308_responder: RTL and testbench

- Synthesizable slave-side model of the LTC2308 serial ADC interface: the far end of the convst/sck/sdi/sdo link that the ADC driver masters.
- Each convst frame latches a sample for the selected channel from a parallel per-channel data bus.
- Shifts that sample out MSB-first on sdo while capturing the next 6-bit config word from sdi.
- Used as the ADC stand-in for bench and board loopback builds of the capture path. It runs on the driver's clock and needs no synchronizers.

---
 rtl/ltc2308_responder.sv | 172 +++++++++++++++++
 tb/tb_ltc2308_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2308_responder.sv
// Slave-side stand-in for an LTC2308 ADC: latches a per-channel sample on each convst
// frame and shifts it out on sdo while capturing the next config word from sdi.
// Optional macro LTC2308_RESP_TWOS_EN: bipolar (UNI=0) frames invert the sample MSB.
module ltc2308_responder #(
   parameter int W           = 12,
   parameter int CFG_BITS    = 6,
   parameter int CONV_CYCLES = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           convst,
   input  logic           sck,
   input  logic           sdi,
   output logic           sdo,
   input  logic [8*W-1:0] chan_data,
   output logic [2:0]     cur_chan,
   output logic           busy,
   output logic           frame_done,
   output logic           err
);

   localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam int BIT_W = $clog2(W + 1);

   // Config word layout {SD, OS, S1, S0, UNI, SLP}
   localparam int CFG_SD  = 5;
   localparam int CFG_OS  = 4;
   localparam int CFG_S1  = 3;
   localparam int CFG_S0  = 2;
   localparam int CFG_UNI = 1;
   localparam int CFG_SLP = 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONVERT,
      S_READY,
      S_SHIFT
   } state_t;

   state_t              state;
   logic                convst_q;
   logic                sck_q;
   logic [CNT_W-1:0]    cnt;
   logic [BIT_W-1:0]    bitcnt;
   logic [W-2:0]        shreg;
   logic [CFG_BITS-1:0] cfg_sh;
   logic [CFG_BITS-1:0] cfg;

   logic                convst_rise;
   logic                sck_rise;
   logic                start_frame;
   logic [2:0]          next_chan;
   logic [CFG_BITS-1:0] cfg_captured;
   logic [W-1:0]        lanes [8];
   logic [W-1:0]        sample;
   logic                cfg_unused;

   assign convst_rise = convst & ~convst_q;
   assign sck_rise    = sck & ~sck_q;
   // A convst rise while converting is only an error; everywhere else it (re)starts a frame.
   assign start_frame = convst_rise && (state != S_CONVERT);
   assign next_chan   = {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};

   always_comb begin
      // NOTE: default first so every path assigns the variable and no latch is inferred.
      cfg_captured = cfg_sh;
      if (bitcnt < BIT_W'(CFG_BITS)) begin
         cfg_captured = {cfg_sh[CFG_BITS-2:0], sdi};
      end
   end

   always_comb begin
      for (int n = 0; n < 8; n++) begin
         lanes[n] = chan_data[n*W +: W];
      end
   end

`ifdef LTC2308_RESP_TWOS_EN
   always_comb begin
      sample        = lanes[cur_chan];
      sample[W-1]   = lanes[cur_chan][W-1] ^ ~cfg[CFG_UNI];
   end
   assign cfg_unused = ^{cfg[CFG_SD], cfg[CFG_SLP]};
`else
   assign sample     = lanes[cur_chan];
   assign cfg_unused = ^{cfg[CFG_SD], cfg[CFG_UNI], cfg[CFG_SLP]};
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         convst_q   <= 1'b0;
         sck_q      <= 1'b0;
         cnt        <= '0;
         bitcnt     <= '0;
         shreg      <= '0;
         cfg_sh     <= '0;
         cfg        <= '0;
         cur_chan   <= 3'd0;
         sdo        <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         convst_q   <= convst;
         sck_q      <= sck;
         frame_done <= 1'b0;

         if (start_frame) begin
            if (state == S_READY || state == S_SHIFT) begin
               err <= 1'b1;
            end
            if (state == S_IDLE && sck_rise) begin
               err <= 1'b1;
            end
            state    <= S_CONVERT;
            cur_chan <= next_chan;
            cnt      <= CNT_W'(CONV_CYCLES - 1);
            busy     <= 1'b1;
            sdo      <= 1'b0;
            bitcnt   <= '0;
            cfg_sh   <= '0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  sdo <= 1'b0;
                  // Any sck rise outside a frame, including beyond the W-th, is a protocol error.
                  if (sck_rise) begin
                     err <= 1'b1;
                  end
               end

               S_CONVERT: begin
                  if (convst_rise || sck_rise) begin
                     err <= 1'b1;
                  end
                  if (cnt == '0) begin
                     shreg <= sample[W-2:0];
                     sdo   <= sample[W-1];
                     busy  <= 1'b0;
                     state <= S_READY;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end

               S_READY, S_SHIFT: begin
                  if (sck_rise) begin
                     cfg_sh <= cfg_captured;
                     bitcnt <= bitcnt + 1'b1;
                     if (bitcnt == BIT_W'(W - 1)) begin
                        sdo        <= 1'b0;
                        frame_done <= 1'b1;
                        cfg        <= cfg_captured;
                        state      <= S_IDLE;
                     end else begin
                        // Next bit appears one clk after the rise, ahead of the driver's next sample.
                        sdo   <= shreg[W-2];
                        shreg <= {shreg[W-3:0], 1'b0};
                        state <= S_SHIFT;
                     end
                  end
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ltc2308_responder.sv
// Self-checking bench for ltc2308_responder: a driver task runs convst/sck/sdi frames and a
// protocol-level model predicts frame data, the sticky error flag and the active channel.
module tb_ltc2308_responder;

   localparam int W           = 12;
   localparam int CFG_BITS    = 6;
   localparam int CONV_CYCLES = 3;

`ifdef LTC2308_RESP_TWOS_EN
   localparam logic [W-1:0] T1_EXP  = 12'h25C;
   localparam logic [W-1:0] T2_EXP  = 12'hBF0;
   localparam logic [W-1:0] T3_EXP  = 12'h8F1;
   localparam logic [W-1:0] T6A_EXP = 12'h800;
`else
   localparam logic [W-1:0] T1_EXP  = 12'hA5C;
   localparam logic [W-1:0] T2_EXP  = 12'h3F0;
   localparam logic [W-1:0] T3_EXP  = 12'h0F1;
   localparam logic [W-1:0] T6A_EXP = 12'h000;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           convst = 1'b0;
   logic           sck = 1'b0;
   logic           sdi = 1'b0;
   logic           sdo;
   logic [8*W-1:0] chan_data = '0;
   logic [2:0]     cur_chan;
   logic           busy;
   logic           frame_done;
   logic           err;

   int n_cmp = 0;
   int n_bad = 0;
   int fd_cnt = 0;

   // Model state: committed config, expected sticky error, expected active channel.
   logic [CFG_BITS-1:0] m_cfg = '0;
   logic                m_err = 1'b0;
   logic [2:0]          m_chan = 3'd0;

   ltc2308_responder #(
      .W(W), .CFG_BITS(CFG_BITS), .CONV_CYCLES(CONV_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .convst(convst), .sck(sck), .sdi(sdi), .sdo(sdo),
      .chan_data(chan_data), .cur_chan(cur_chan), .busy(busy),
      .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] model_chan(input logic [CFG_BITS-1:0] c);
      return 3'(4 * int'(c[3]) + 2 * int'(c[2]) + int'(c[4]));
   endfunction

   function automatic logic [W-1:0] model_sample(input logic [CFG_BITS-1:0] c);
      logic [8*W-1:0] sh;
      int v;
      sh = chan_data >> (int'(model_chan(c)) * W);
      v  = int'(sh[W-1:0]);
`ifdef LTC2308_RESP_TWOS_EN
      if (c[1] == 1'b0) v = (v + 2 ** (W - 1)) % (2 ** W);
`endif
      return W'(v);
   endfunction

   task automatic set_lane(input int n, input logic [W-1:0] v);
      chan_data[n*W +: W] = v;
   endtask

   // Called at a falling clk edge; pulls reset low between clk edges.
   task automatic apply_reset();
      m_err  = 1'b0;
      m_chan = 3'd0;
      m_cfg  = '0;
      convst = 1'b0;
      sck    = 1'b0;
      sdi    = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rst_sdo", sdo, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_frame_done", frame_done, 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_frame(input logic [CFG_BITS-1:0] cfg_word, input logic [CFG_BITS-1:0] junk_cfg,
                            input int abort_after, input int rst_after, input bit early_sck,
                            input bit tamper, output logic [W-1:0] res);
      logic [W-1:0] exp;
      int  nbusy;
      int  fd_before;
      bit  got, aborted, again, killed;
      aborted   = 1'b0;
      killed    = 1'b0;
      res       = '0;
      exp       = '0;
      fd_before = fd_cnt;
      @(negedge clk);
      convst = 1'b1;
      m_chan = model_chan(m_cfg);
      do begin
         again = 1'b0;
         nbusy = 0;
         got   = 1'b0;
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            convst = 1'b0;
            sck    = early_sck && !aborted && (c == 2);
            if (sck) m_err = 1'b1;
            if (busy) nbusy++;
            else begin
               got = 1'b1;
               break;
            end
         end
         check("busy_released", got, 1);
         check("busy_cycles", nbusy, CONV_CYCLES);
         exp = model_sample(m_cfg);
         if (tamper) chan_data = ~chan_data;
         for (int i = 0; i < W; i++) begin
            if (abort_after > 0 && !aborted && i == abort_after) begin
               convst  = 1'b1;
               m_err   = 1'b1;
               aborted = 1'b1;
               again   = 1'b1;
               break;
            end
            if (rst_after > 0 && i == rst_after) begin
               apply_reset();
               killed = 1'b1;
               break;
            end
            res[W-1-i] = sdo;
            if (i < CFG_BITS)
               sdi = (abort_after > 0 && !aborted) ? junk_cfg[CFG_BITS-1-i] : cfg_word[CFG_BITS-1-i];
            else
               sdi = 1'b0;
            sck = 1'b1;
            @(negedge clk);
            sck = 1'b0;
            if (i == W - 1) begin
               check("frame_done_pulse", frame_done, 1);
               check("sdo_after_frame", sdo, 0);
            end
            @(negedge clk);
         end
         if (tamper) chan_data = ~chan_data;
      end while (again);
      sdi = 1'b0;
      if (!killed) begin
         check("frame_data", res, exp);
         check("frame_done_count", fd_cnt - fd_before, 1);
         m_cfg = cfg_word;
      end
   endtask

   // Per-cycle comparison of the sticky error flag and active channel against the model.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         check("err_track", err, m_err);
         check("cur_chan_track", cur_chan, m_chan);
         if (frame_done) fd_cnt++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] res;
      int fd_before;
      set_lane(0, 12'hA5C);
      set_lane(1, 12'h1B7);
      set_lane(2, 12'h3F0);
      set_lane(3, 12'h6D2);
      set_lane(4, 12'h0F1);
      set_lane(5, 12'hE39);
      set_lane(6, 12'h47C);
      set_lane(7, 12'h9A3);
      repeat (3) @(negedge clk);
      check("reset_sdo", sdo, 0);
      check("reset_busy", busy, 0);
      check("reset_frame_done", frame_done, 0);
      check("reset_err", err, 0);
      check("reset_cur_chan", cur_chan, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: plain frame from channel 0
      run_frame(6'b000000, 6'b000000, 0, 0, 1'b0, 1'b0, res);
      check("t1_literal", res, T1_EXP);
      check("t1_err", err, 0);

      // 2: select channel 2, then read it while chan_data changes after the latch
      run_frame(6'b100100, 6'b000000, 0, 0, 1'b0, 1'b0, res);
      check("t2_first_literal", res, T1_EXP);
      run_frame(6'b000000, 6'b000000, 0, 0, 1'b0, 1'b1, res);
      check("t2_literal", res, T2_EXP);
      check("t2_cur_chan", cur_chan, 3'd2);

      // 3: convst after 5 sck rises aborts; junk config is not committed
      run_frame(6'b001000, 6'b111100, 5, 0, 1'b0, 1'b0, res);
      check("t3_restart_literal", res, T1_EXP);
      check("t3_err", err, 1);
      run_frame(6'b000100, 6'b000000, 0, 0, 1'b0, 1'b0, res);
      check("t3_next_literal", res, T3_EXP);

      // 4: async reset mid-shift, next frame falls back to channel 0
      run_frame(6'b011000, 6'b000000, 0, 6, 1'b0, 1'b0, res);
      check("t4_err_cleared", err, 0);
      run_frame(6'b000000, 6'b000000, 0, 0, 1'b0, 1'b0, res);
      check("t4_literal", res, T1_EXP);

      // 5: sck during conversion flags error but data still shifts out
      run_frame(6'b000000, 6'b000000, 0, 0, 1'b1, 1'b0, res);
      check("t5_literal", res, T1_EXP);
      check("t5_err", err, 1);

      // Extra sck rise after a complete frame
      @(negedge clk);
      apply_reset();
      run_frame(6'b000000, 6'b000000, 0, 0, 1'b0, 1'b0, res);
      check("extra_pre_err", err, 0);
      fd_before = fd_cnt;
      @(negedge clk);
      sck   = 1'b1;
      m_err = 1'b1;
      @(negedge clk);
      sck = 1'b0;
      check("extra_sdo", sdo, 0);
      @(negedge clk);
      check("extra_err", err, 1);
      check("extra_no_done", fd_cnt - fd_before, 0);

      // 6: zero sample under bipolar then unipolar config
      set_lane(0, 12'h000);
      run_frame(6'b000010, 6'b000000, 0, 0, 1'b0, 1'b0, res);
      check("t6_bipolar", res, T6A_EXP);
      run_frame(6'b000000, 6'b000000, 0, 0, 1'b0, 1'b0, res);
      check("t6_unipolar", res, 12'h000);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
